// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - program counter with next-PC selection, stall/exception redirect
// and a return-address stack that scores return targets against rs_val.
module pc_unit_ras #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter int              RAS_DEPTH  = 8,
  parameter int              CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         exc_req,
  input  logic [2:0]                   npc_op,
  input  logic [25:0]                  imm,
  input  logic [WIDTH-1:0]             rs_val,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus4,
  output logic [WIDTH-1:0]             npc,
  output logic [WIDTH-1:0]             ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_hit,
  output logic                         ras_miss,
  output logic                         ras_ovf,
  output logic                         ras_unf,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             miss_cnt
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    OP_PLUS4  = 3'b000,
    OP_BRANCH = 3'b001,
    OP_JUMP   = 3'b010,
    OP_JR     = 3'b011,
    OP_JAL    = 3'b100,
    OP_RET    = 3'b101
  } npc_op_e;

  npc_op_e          op;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] jmp_tgt;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_m1;
  logic             ras_full;
  logic             ras_empty;
  logic             advance;
  logic             ret_hit;

  assign op       = npc_op_e'(npc_op);
  assign pc_plus4 = pc + WIDTH'(4);
  assign br_off   = {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
  assign jmp_tgt  = {pc_plus4[WIDTH-1:28], imm, 2'b00};

  always_comb begin
    npc = pc_plus4;
    if (exc_req) begin
      npc = EXC_VECTOR;
    end else begin
      case (op)
        OP_BRANCH:       npc = pc_plus4 + br_off;
        OP_JUMP, OP_JAL: npc = jmp_tgt;
        OP_JR, OP_RET:   npc = rs_val;
        default:         npc = pc_plus4;
      endcase
    end
  end

  // ptr points at the next free slot, so the top of stack sits one below it
  assign ptr_m1    = ptr - PW'(1);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);
  assign ras_top   = ras_empty ? '0 : ras_mem[ptr_m1];
  assign advance   = !exc_req && !stall;
  assign ret_hit   = !ras_empty && (ras_mem[ptr_m1] == rs_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ptr       <= '0;
      ras_count <= '0;
      ras_hit   <= 1'b0;
      ras_miss  <= 1'b0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      ras_hit  <= 1'b0;
      ras_miss <= 1'b0;

      if (exc_req) begin
        pc <= EXC_VECTOR;
      end else if (!stall) begin
        pc <= npc;
      end

      // a push into a full stack overwrites the oldest entry
      if (advance && op == OP_JAL) begin
        ras_mem[ptr] <= pc_plus4;
        ptr          <= ptr + PW'(1);
        if (ras_full) begin
          ras_ovf <= 1'b1;
        end else begin
          ras_count <= ras_count + CW'(1);
        end
      end

      if (advance && op == OP_RET) begin
        if (!ras_empty) begin
          ptr       <= ptr_m1;
          ras_count <= ras_count - CW'(1);
        end else begin
          ras_unf <= 1'b1;
        end
        if (ret_hit) begin
          ras_hit <= 1'b1;
          if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
        end else begin
          ras_miss <= 1'b1;
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - directed vector table plus hand sequences for pc_unit_ras.
module tb_pc_unit_ras;

  localparam logic [2:0] P4 = 3'd0, BR = 3'd1, JP = 3'd2, JR = 3'd3, JAL = 3'd4, RET = 3'd5;

  logic        clk = 1'b0;
  logic        rst, stall, exc_req;
  logic [2:0]  npc_op;
  logic [25:0] imm;
  logic [31:0] rs_val;
  logic [31:0] pc, pc_plus4, npc, ras_top;
  logic [3:0]  ras_count;
  logic        ras_hit, ras_miss, ras_ovf, ras_unf;
  logic [15:0] hit_cnt, miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_unit_ras dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req), .npc_op(npc_op),
    .imm(imm), .rs_val(rs_val), .pc(pc), .pc_plus4(pc_plus4), .npc(npc),
    .ras_top(ras_top), .ras_count(ras_count), .ras_hit(ras_hit), .ras_miss(ras_miss),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    logic        rst, stall, exc;
    logic [2:0]  op;
    logic [25:0] imm;
    logic [31:0] rs;
    logic        chk_npc;
    logic [31:0] npc_e, pc_e;
    logic [3:0]  cnt_e;
    logic [31:0] top_e;
    logic [3:0]  flg_e;
    logic [15:0] hc_e, mc_e;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic e, input logic [2:0] op,
                     input logic [25:0] im, input logic [31:0] rs, input logic cn,
                     input logic [31:0] npc_e, input logic [31:0] pc_e, input logic [3:0] cnt,
                     input logic [31:0] top, input logic [3:0] flg,
                     input logic [15:0] hc, input logic [15:0] mc);
    vec_t v;
    v.rst = r; v.stall = s; v.exc = e; v.op = op; v.imm = im; v.rs = rs;
    v.chk_npc = cn; v.npc_e = npc_e; v.pc_e = pc_e; v.cnt_e = cnt; v.top_e = top;
    v.flg_e = flg; v.hc_e = hc; v.mc_e = mc;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic e, input logic [2:0] op,
                       input logic [25:0] im, input logic [31:0] rs);
    rst = r; stall = s; exc_req = e; npc_op = op; imm = im; rs_val = rs;
  endtask

  // state check after an edge; flags packed {hit, miss, ovf, unf}
  task automatic chk_state(input string tag, input logic [31:0] pc_e, input logic [3:0] cnt_e,
                           input logic [31:0] top_e, input logic [3:0] flg_e,
                           input logic [15:0] hc_e, input logic [15:0] mc_e);
    chk({tag, "_pc"}, pc, pc_e);
    chk({tag, "_cnt"}, 32'(ras_count), 32'(cnt_e));
    chk({tag, "_top"}, ras_top, top_e);
    chk({tag, "_flags"}, 32'({ras_hit, ras_miss, ras_ovf, ras_unf}), 32'(flg_e));
    chk({tag, "_hitcnt"}, 32'(hit_cnt), 32'(hc_e));
    chk({tag, "_misscnt"}, 32'(miss_cnt), 32'(mc_e));
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, P4, '0, '0);

    // reset and sequential fetch, backward branch
    add(1,0,0,P4, 0, 0, 0, 32'h0,    32'h3000, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,P4, 0, 0, 1, 32'h3004, 32'h3004, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,P4, 0, 0, 1, 32'h3008, 32'h3008, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,P4, 0, 0, 1, 32'h300C, 32'h300C, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,BR, 26'hFFFE, 0, 1, 32'h3008, 32'h3008, 0, 0, 4'b0000, 0, 0);
    // jump, stalled JAL, JR, undefined op
    add(1,0,0,P4, 0, 0, 1, 32'h300C, 32'h3000, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,JP, 26'h100, 0, 1, 32'h0400, 32'h0400, 0, 0, 4'b0000, 0, 0);
    add(0,1,0,JAL,26'h100, 0, 1, 32'h0400, 32'h0400, 0, 0, 4'b0000, 0, 0);
    add(0,1,0,JAL,26'h100, 0, 1, 32'h0400, 32'h0400, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,JR, 0, 32'h1234, 1, 32'h1234, 32'h1234, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,3'd6, 0, 0, 1, 32'h1238, 32'h1238, 0, 0, 4'b0000, 0, 0);
    // call/return hit, then underflow miss
    add(1,0,0,P4, 0, 0, 1, 32'h123C, 32'h3000, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,JAL,26'h400, 0, 1, 32'h1000, 32'h1000, 1, 32'h3004, 4'b0000, 0, 0);
    add(0,0,0,RET,0, 32'h3004, 1, 32'h3004, 32'h3004, 0, 0, 4'b1000, 1, 0);
    add(0,0,0,RET,0, 32'h3004, 1, 32'h3004, 32'h3004, 0, 0, 4'b0101, 1, 1);
    add(0,0,0,P4, 0, 0, 1, 32'h3008, 32'h3008, 0, 0, 4'b0001, 1, 1);
    // nine calls into an eight-deep stack, eight matching returns, one underflow
    add(1,0,0,P4, 0, 0, 1, 32'h300C, 32'h3000, 0, 0, 4'b0000, 0, 0);
    for (int k = 1; k <= 9; k++)
      add(0,0,0,JAL, 26'hC00 + 26'(k), 0, 1, 32'h3000 + 32'(4*k), 32'h3000 + 32'(4*k),
          (k > 8) ? 4'd8 : 4'(k), 32'h3000 + 32'(4*k), (k == 9) ? 4'b0010 : 4'b0000, 0, 0);
    for (int j = 1; j <= 8; j++)
      add(0,0,0,RET, 0, 32'h3028 - 32'(4*j), 1, 32'h3028 - 32'(4*j), 32'h3028 - 32'(4*j),
          4'(8 - j), (j == 8) ? 32'h0 : 32'h3024 - 32'(4*j), 4'b1010, 16'(j), 0);
    add(0,0,0,RET,0, 32'h3000, 1, 32'h3000, 32'h3000, 0, 0, 4'b0111, 8, 1);
    // mispredicted return
    add(1,0,0,P4, 0, 0, 1, 32'h3004, 32'h3000, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,JAL,26'hC01, 0, 1, 32'h3004, 32'h3004, 1, 32'h3004, 4'b0000, 0, 0);
    add(0,0,0,JAL,26'hC02, 0, 1, 32'h3008, 32'h3008, 2, 32'h3008, 4'b0000, 0, 0);
    add(0,0,0,RET,0, 32'h5000, 1, 32'h5000, 32'h5000, 1, 32'h3004, 4'b0100, 0, 1);
    add(0,0,0,P4, 0, 0, 1, 32'h5004, 32'h5004, 1, 32'h3004, 4'b0000, 0, 1);
    // exception over stall and over RET, then mid-sequence reset
    add(1,0,0,P4, 0, 0, 1, 32'h5008, 32'h3000, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,JAL,26'hC01, 0, 1, 32'h3004, 32'h3004, 1, 32'h3004, 4'b0000, 0, 0);
    add(0,0,0,JAL,26'hC02, 0, 1, 32'h3008, 32'h3008, 2, 32'h3008, 4'b0000, 0, 0);
    add(0,0,0,JAL,26'hC03, 0, 1, 32'h300C, 32'h300C, 3, 32'h300C, 4'b0000, 0, 0);
    add(0,1,1,JAL,26'hC04, 0, 1, 32'h4180, 32'h4180, 3, 32'h300C, 4'b0000, 0, 0);
    add(0,0,1,RET,0, 32'h300C, 1, 32'h4180, 32'h4180, 3, 32'h300C, 4'b0000, 0, 0);
    add(0,0,0,RET,0, 32'h300C, 1, 32'h300C, 32'h300C, 2, 32'h3008, 4'b1000, 1, 0);
    add(0,0,0,JAL,26'hC04, 0, 1, 32'h3010, 32'h3010, 3, 32'h3010, 4'b0000, 1, 0);
    add(1,0,0,P4, 0, 0, 1, 32'h3014, 32'h3000, 0, 0, 4'b0000, 0, 0);
    add(0,0,0,JAL,26'hC01, 0, 1, 32'h3004, 32'h3004, 1, 32'h3004, 4'b0000, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].stall, vq[i].exc, vq[i].op, vq[i].imm, vq[i].rs);
      #1;
      if (vq[i].chk_npc) chk($sformatf("v%0d_npc", i), npc, vq[i].npc_e);
      @(posedge clk); #1;
      chk_state($sformatf("v%0d", i), vq[i].pc_e, vq[i].cnt_e, vq[i].top_e,
                vq[i].flg_e, vq[i].hc_e, vq[i].mc_e);
      @(negedge clk);
    end

    // stalled RET holds the stack and emits no pulse until released
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, 1'b1, 1'b0, RET, '0, 32'h3004);
      @(posedge clk); #1;
      chk_state($sformatf("stall_ret%0d", s), 32'h3004, 4'd1, 32'h3004, 4'b0000, 0, 0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, RET, '0, 32'h3004);
    @(posedge clk); #1;
    chk_state("released_ret", 32'h3004, 4'd0, 32'h0, 4'b1000, 1, 0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, RET, '0, 32'h3004);
    @(posedge clk); #1;
    chk_state("pulse_drop", 32'h3004, 4'd0, 32'h0, 4'b0000, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Next-generation program-counter block for the single-cycle CPU: owns the PC register and computes the next PC.
- Extends next-PC selection with register-indirect jumps, call/return handling, stall and exception redirect.
- Contains a parametrised return-address stack (RAS) that checks return targets against the authoritative rs value and keeps hit/miss statistics.
- Sits between the control unit (npc_op, stall, exc_req), the register file (rs_val) and instruction memory (pc).

Parameters:
- WIDTH, 32: PC/data width; must be >= 32.
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180: PC value loaded on exception.
- RAS_DEPTH, 8: RAS entries; power of 2, >= 2.
- CNT_W, 16: width of the hit/miss counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS state.
- exc_req  in  1  redirect to EXC_VECTOR.
- npc_op  in  3  000 PLUS4, 001 BRANCH, 010 JUMP, 011 JR, 100 JAL, 101 RET; 110/111 behave as PLUS4.
- imm  in  26  instruction immediate / jump index.
- rs_val  in  WIDTH  register target for JR/RET.
- pc  out  WIDTH  current PC (registered).
- pc_plus4  out  WIDTH  pc+4 (combinational); link value for JAL.
- npc  out  WIDTH  next PC (combinational).
- ras_top  out  WIDTH  top RAS entry; 0 when empty.
- ras_count  out  clog2(RAS_DEPTH)+1  valid entries.
- ras_hit  out  1  registered one-cycle pulse.
- ras_miss  out  1  registered one-cycle pulse.
- ras_ovf  out  1  sticky overflow flag.
- ras_unf  out  1  sticky underflow flag.
- hit_cnt  out  CNT_W  saturating count of return hits.
- miss_cnt  out  CNT_W  saturating count of return misses.

Behaviour:
- Reset (sync, rst=1 at edge):
  - pc=RESET_PC.
  - RAS pointer=0, ras_count=0, all entries 0.
  - ras_hit=ras_miss=0, ras_ovf=ras_unf=0, hit_cnt=miss_cnt=0.
  - rst has priority over everything.
- npc (combinational), with p4 = pc+4 modulo 2^WIDTH:
  - PLUS4: npc = p4.
  - BRANCH: npc = p4 + sign-extended {imm[15:0],2'b00}.
  - JUMP/JAL: npc = {p4[WIDTH-1:28], imm, 2'b00}.
  - JR/RET: npc = rs_val.
  - exc_req=1 overrides all ops: npc = EXC_VECTOR.
- PC update priority each edge: rst > exc_req (pc<=EXC_VECTOR, even if stall=1) > stall (hold) > pc<=npc.
- Advance = !rst && !exc_req && !stall. RAS, flags and counters change only on an advance; stall or exc_req suppresses push/pop.
- JAL on advance (push):
  - entry[ptr] <= p4; ptr <= ptr+1 mod RAS_DEPTH.
  - Count below RAS_DEPTH: count increments.
  - Count already RAS_DEPTH: the oldest entry is overwritten (wrap), count stays RAS_DEPTH, ras_ovf <= 1.
- RET on advance (pop):
  - Count > 0: compare entry[ptr-1] with rs_val. Equal gives hit; otherwise miss. Then ptr <= ptr-1, count decrements.
  - Count = 0: counts as a miss, ras_unf <= 1, ptr and count unchanged.
  - The PC always follows rs_val regardless of the compare.
- ras_hit/ras_miss are asserted for exactly the one cycle after the RET edge; 0 otherwise, including during stall.
- hit_cnt/miss_cnt increment with the corresponding pulse; they saturate at all-ones.
- ras_top = entry[ptr-1] when count > 0, else 0.
- ras_ovf/ras_unf stay set until reset.
- No other ops touch the RAS.

Test Plan:
1. Reset, then 3 PLUS4 cycles -> pc 3000, 3004, 3008, 300C. Then BRANCH with imm=16'hFFFE at pc=300C -> npc=3008.
2. JUMP at pc=3000 with imm=26'h0000100 -> pc=00000400. Stall=1 for 2 cycles with op=JAL -> pc held and ras_count stays 0.
3. JAL at 3000 (imm 0x400) then RET with rs_val=3004 -> ras_count 1 then 0, pc=3004. ras_hit pulses one cycle and hit_cnt=1. RET again with rs_val=3004 -> ras_unf=1, miss_cnt=1, pc=3004.
4. 9 JALs with RAS_DEPTH=8 -> ras_count=8, ras_ovf=1, ras_top = last link address. 8 RETs with matching rs_val -> 8 hits; the 9th RET underflows.
5. RET with rs_val differing from ras_top -> ras_miss pulse, pc=rs_val, entry popped.
6. exc_req=1 with stall=1 and op=JAL -> pc=4180 and no push. rst asserted mid-sequence with count=3 -> next cycle pc=3000 and all RAS state/counters cleared.
